// File: rtl/bp_me_mem_cmd_arbiter.sv
// bp_me_mem_cmd_arbiter: round-robin share of one bp_mem port, with in-order tag FIFO steering responses back
module bp_me_mem_cmd_arbiter #(
  parameter int msg_width_p       = 8,
  parameter int num_req_p         = 2,
  parameter int max_outstanding_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p*msg_width_p-1:0] cmd_i,
  input  logic [num_req_p-1:0]           cmd_v_i,
  output logic [num_req_p-1:0]           cmd_yumi_o,
  output logic [msg_width_p-1:0]         resp_o,
  output logic [num_req_p-1:0]           resp_v_o,
  input  logic [num_req_p-1:0]           resp_yumi_i,
  output logic [msg_width_p-1:0]         mem_cmd_o,
  output logic                           mem_cmd_v_o,
  input  logic                           mem_cmd_yumi_i,
  input  logic [msg_width_p-1:0]         mem_resp_i,
  input  logic                           mem_resp_v_i,
  output logic                           mem_resp_ready_o
);
  localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int lg_out_lp = $clog2(max_outstanding_p);
  logic [lg_req_lp-1:0] rr_ptr_r, lock_id_r, rbuf_id_r, grant, search, idx;
  logic                 lock_v_r, rbuf_v_r, tag_full, tag_empty, push, pop, take;
  logic [msg_width_p-1:0] rbuf_data_r;
  logic [lg_req_lp-1:0] tag_mem [max_outstanding_p];
  logic [lg_out_lp-1:0] wptr_r, rptr_r;
  logic [lg_out_lp:0]   cnt_r;
  // descending scan so the closest valid source above rr_ptr wins
  always_comb begin
    search = rr_ptr_r;
    idx = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      idx = lg_req_lp'((int'(rr_ptr_r) + k) % num_req_p);
      if (cmd_v_i[idx]) search = idx;
    end
  end
  always_comb begin
    mem_cmd_o = '0;
    for (int i = 0; i < num_req_p; i++)
      if (grant == lg_req_lp'(i)) mem_cmd_o = cmd_i[i*msg_width_p +: msg_width_p];
  end
  assign grant            = lock_v_r ? lock_id_r : search;
  assign tag_full         = cnt_r == (lg_out_lp+1)'(max_outstanding_p);
  assign tag_empty        = cnt_r == '0;
  assign mem_cmd_v_o      = cmd_v_i[grant] & ~tag_full;
  assign push             = mem_cmd_yumi_i;
  assign mem_resp_ready_o = ~rbuf_v_r | resp_yumi_i[rbuf_id_r];
  assign take             = mem_resp_v_i & mem_resp_ready_o;
  assign pop              = take & ~tag_empty;
  assign resp_o           = rbuf_data_r;
  for (genvar j = 0; j < num_req_p; j++) begin : g_src
    assign cmd_yumi_o[j] = mem_cmd_yumi_i & (grant == lg_req_lp'(j));
    assign resp_v_o[j]   = rbuf_v_r & (rbuf_id_r == lg_req_lp'(j));
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_r    <= '0;
      lock_v_r    <= 1'b0;
      lock_id_r   <= '0;
      wptr_r      <= '0;
      rptr_r      <= '0;
      cnt_r       <= '0;
      rbuf_v_r    <= 1'b0;
      rbuf_id_r   <= '0;
      rbuf_data_r <= '0;
    end else begin
      if (push) begin
        rr_ptr_r <= (grant == lg_req_lp'(num_req_p - 1)) ? '0 : grant + 1'b1;
        lock_v_r <= 1'b0;
        wptr_r   <= wptr_r + 1'b1;
      end else if (mem_cmd_v_o) begin
        lock_v_r  <= 1'b1;
        lock_id_r <= grant;
      end
      if (pop) rptr_r <= rptr_r + 1'b1;
      if (pop) rbuf_id_r <= tag_mem[rptr_r];
      if (take) rbuf_data_r <= mem_resp_i;
      cnt_r    <= cnt_r + (lg_out_lp+1)'(push) - (lg_out_lp+1)'(pop);
      // a response taken with no tag outstanding is dropped, leaving the buffer empty
      rbuf_v_r <= pop | (rbuf_v_r & ~(take | resp_yumi_i[rbuf_id_r]));
    end
  end
  always_ff @(posedge clk_i)
    if (push) tag_mem[wptr_r] <= grant;
`ifndef SYNTHESIS
  always_ff @(posedge clk_i)
    if (!reset_i && take) assert (!tag_empty) else $error("response with no outstanding command");
`endif
endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// tb_bp_me_mem_cmd_arbiter: directed and random stimulus against a queue-based reference model
module tb_bp_me_mem_cmd_arbiter;
  logic clk = 0, reset_i;
  logic [15:0] cmd_i;
  logic [1:0] cmd_v_i, cmd_yumi_o, resp_v_o, resp_yumi_i;
  logic [7:0] resp_o, mem_cmd_o, mem_resp_i;
  logic mem_cmd_v_o, mem_cmd_yumi_i, mem_resp_v_i, mem_resp_ready_o;
  int vectors = 0, miscompares = 0;
  int rr, lsrc, bsrc;
  bit lk, bv;
  logic [7:0] bd;
  int tq[$];
  logic [1:0] last_yumi, last_rv;
  logic last_ready, last_mv;
  bp_me_mem_cmd_arbiter #(.msg_width_p(8), .num_req_p(2), .max_outstanding_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_yumi_o(cmd_yumi_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock: apply inputs, compare against the model, then advance the model
  task automatic step(input logic rst, input logic [1:0] cv, input logic [7:0] c0, input logic [7:0] c1,
                      input logic my, input logic rv, input logic [7:0] rd, input logic [1:0] ry);
    int g;
    logic ev, er;
    logic [7:0] cmds [2];
    cmds[0] = c0;
    cmds[1] = c1;
    g = rr;
    if (lk) g = lsrc;
    else if (!cv[rr] && cv[1-rr]) g = 1 - rr;
    ev = cv[g] && tq.size() < 4;
    reset_i = rst;
    cmd_v_i = cv;
    cmd_i = {c1, c0};
    mem_cmd_yumi_i = my & ev;
    mem_resp_v_i = rv && tq.size() > 0;
    mem_resp_i = rd;
    resp_yumi_i = ry;
    er = !bv || ry[bsrc];
    #2;
    check("mem_cmd_v", mem_cmd_v_o, ev);
    if (ev) check("mem_cmd", mem_cmd_o, cmds[g]);
    check("cmd_yumi", cmd_yumi_o, mem_cmd_yumi_i ? (2'b01 << g) : 2'b00);
    check("resp_v", resp_v_o, bv ? (2'b01 << bsrc) : 2'b00);
    if (bv) check("resp_data", resp_o, bd);
    check("resp_ready", mem_resp_ready_o, er);
    last_yumi = cmd_yumi_o;
    last_rv = resp_v_o;
    last_ready = mem_resp_ready_o;
    last_mv = mem_cmd_v_o;
    @(posedge clk);
    if (rst) begin
      rr = 0; lk = 0; bv = 0; tq.delete();
    end else begin
      if (mem_resp_v_i && er) begin
        if (tq.size() > 0) begin
          bsrc = tq.pop_front(); bd = rd; bv = 1;
        end else bv = 0;
      end else if (bv && ry[bsrc]) bv = 0;
      if (mem_cmd_yumi_i) begin
        tq.push_back(g); rr = (g + 1) % 2; lk = 0;
      end else if (ev) begin
        lk = 1; lsrc = g;
      end
    end
    #1;
  endtask
  initial begin
    rr = 0; lsrc = 0; bsrc = 0; lk = 0; bv = 0; bd = 0;
    reset_i = 1; cmd_v_i = 0; cmd_i = 0; mem_cmd_yumi_i = 0; mem_resp_v_i = 0; mem_resp_i = 0; resp_yumi_i = 0;
    @(posedge clk); #1;
    step(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    check("reset_mem_cmd_v", last_mv, 1'b0);
    check("reset_ready", last_ready, 1'b1);
    check("reset_resp_v", last_rv, 2'b00);
    // round-robin with both always valid until the tag FIFO fills
    step(0, 3, 8'h10, 8'h11, 1, 0, 8'h00, 0); check("rr0", last_yumi, 2'b01);
    step(0, 3, 8'h12, 8'h13, 1, 0, 8'h00, 0); check("rr1", last_yumi, 2'b10);
    step(0, 3, 8'h14, 8'h15, 1, 0, 8'h00, 0); check("rr2", last_yumi, 2'b01);
    step(0, 3, 8'h16, 8'h17, 1, 0, 8'h00, 0); check("rr3", last_yumi, 2'b10);
    step(0, 3, 8'h18, 8'h19, 1, 0, 8'h00, 0); check("full_v", last_mv, 1'b0);
    // full with a response arriving: pop only, push opens next cycle
    step(0, 3, 8'h18, 8'h19, 1, 1, 8'hA0, 3); check("full_pop_v", last_mv, 1'b0);
    step(0, 3, 8'h18, 8'h19, 0, 1, 8'hA1, 3); check("reopen_v", last_mv, 1'b1);
    step(0, 0, 8'h00, 8'h00, 0, 1, 8'hA2, 3);
    // reset with outstanding commands
    step(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    step(0, 3, 8'h20, 8'h21, 0, 0, 8'h00, 0); check("rst_rr", mem_cmd_o, 8'h20);
    step(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    // lock: source 1 waits, source 0 raises valid meanwhile
    step(0, 2, 8'h30, 8'h31, 0, 0, 8'h00, 0);
    step(0, 3, 8'h30, 8'h31, 0, 0, 8'h00, 0); check("lock_cmd", mem_cmd_o, 8'h31);
    step(0, 3, 8'h30, 8'h31, 0, 0, 8'h00, 0);
    step(0, 3, 8'h30, 8'h31, 1, 0, 8'h00, 0); check("lock_yumi", last_yumi, 2'b10);
    step(0, 1, 8'h30, 8'h00, 1, 0, 8'h00, 0); check("after_lock", last_yumi, 2'b01);
    // A(src1), B(src0), C(src1) then back-to-back responses
    step(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    step(0, 2, 8'h00, 8'h41, 1, 0, 8'h00, 0);
    step(0, 1, 8'h42, 8'h00, 1, 0, 8'h00, 0);
    step(0, 2, 8'h00, 8'h43, 1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 8'h00, 0, 1, 8'hB1, 3);
    step(0, 0, 8'h00, 8'h00, 0, 1, 8'hB2, 3); check("b2b_1", last_rv, 2'b10);
    step(0, 0, 8'h00, 8'h00, 0, 1, 8'hB3, 3); check("b2b_2", last_rv, 2'b01);
    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 3); check("b2b_3", last_rv, 2'b10);
    // source 0 withholds resp_yumi_i
    step(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    step(0, 1, 8'h50, 8'h00, 1, 0, 8'h00, 0);
    step(0, 1, 8'h51, 8'h00, 1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 8'h00, 0, 1, 8'hC0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'h00, 8'h00, 0, 1, 8'hC1, 0);
      check("hold_ready", last_ready, 1'b0);
    end
    step(0, 0, 8'h00, 8'h00, 0, 1, 8'hC1, 1); check("yumi_ready", last_ready, 1'b1);
    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 250) == 0, 2'($urandom), 8'($urandom), 8'($urandom), ($urandom % 4) != 0,
           ($urandom % 3) != 0, 8'($urandom), 2'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
